// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage.
// Holds the EXE->MEM and MEM->WB bundle widths, the bit offsets of every
// field inside those bundles, and the state encoding of the read-data
// capture register.
package mem_stage_pkg;

    // EXE->MEM bundle: {pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}
    localparam int EXE2MEM_W       = 71;
    localparam int EM_ALU_LSB      = 0;
    localparam int EM_WADDR_LSB    = 32;
    localparam int EM_RF_WE        = 37;
    localparam int EM_RES_FROM_MEM = 38;
    localparam int EM_PC_LSB       = 39;

    // MEM->WB bundle: {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
    localparam int MEM2WB_W        = 70;
    localparam int WB_RESULT_LSB   = 0;
    localparam int WB_WADDR_LSB    = 32;
    localparam int WB_RF_WE        = 37;
    localparam int WB_PC_LSB       = 38;

    // Read-data capture: FRESH uses the live SRAM data, HELD uses the copy.
    typedef enum logic {
        RD_FRESH = 1'b0,
        RD_HELD  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the EXE->MEM, SRAM read-data, MEM->WB and forwarding signals
// around the memory-access stage.
//   slave  : the mem_stage side (takes EXE bundle, SRAM data, WB_allowin;
//            drives allowin, WB bundle and forwarding outputs)
//   master : the surrounding pipeline / environment side
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                 MEM_signal_valid;
    logic                 EXE_readygo;
    logic [EXE2MEM_W-1:0] MEM_signal;
    logic [31:0]          data_sram_rdata;
    logic                 WB_allowin;
    logic                 MEM_allowin;
    logic                 WB_signal_valid;
    logic [MEM2WB_W-1:0]  WB_signal;
    logic                 MEM_fwd_we;
    logic [4:0]           MEM_fwd_waddr;
    logic [31:0]          MEM_fwd_wdata;

    modport slave (
        input  MEM_signal_valid, EXE_readygo, MEM_signal, data_sram_rdata, WB_allowin,
        output MEM_allowin, WB_signal_valid, WB_signal,
               MEM_fwd_we, MEM_fwd_waddr, MEM_fwd_wdata
    );

    modport master (
        output MEM_signal_valid, EXE_readygo, MEM_signal, data_sram_rdata, WB_allowin,
        input  MEM_allowin, WB_signal_valid, WB_signal,
               MEM_fwd_we, MEM_fwd_waddr, MEM_fwd_wdata
    );

endinterface

// File: rtl/mem_stage_rdata_hold.sv
// mem_rdata_hold: FRESH/HELD capture register for the data-SRAM read data.
// While the instruction in MEM waits on WB, EXE keeps re-issuing its own
// request, so the live read data stops belonging to the MEM instruction.
// This block snapshots the data on the first stalled cycle and serves the
// snapshot until MEM turns over.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   capture     : MEM holds a valid load and WB is not accepting
//   clear       : MEM updates this edge (new bundle or bubble)
//   rdata_in    : live data-SRAM read data
//   rdata_sel   : read data belonging to the instruction in MEM
//   hold_vld    : 1 while the snapshot is being served
module mem_rdata_hold
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] rdata_in,
    output logic [31:0] rdata_sel,
    output logic        hold_vld
);

    rd_state_e   state_q;
    rd_state_e   state_d;
    logic        load_hold;
    logic [31:0] rdata_hold;

    always_comb begin
        state_d   = state_q;
        load_hold = 1'b0;
        case (state_q)
            RD_FRESH: begin
                // Snapshot only on the first stalled cycle; later stalled
                // cycles see data for EXE's request and must be ignored.
                if (capture && !clear) begin
                    state_d   = RD_HELD;
                    load_hold = 1'b1;
                end
            end
            RD_HELD: begin
                if (clear) begin
                    state_d = RD_FRESH;
                end
            end
            default: state_d = RD_FRESH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RD_FRESH;
            rdata_hold <= 32'd0;
        end else begin
            state_q <= state_d;
            if (load_hold) begin
                rdata_hold <= rdata_in;
            end
        end
    end

    assign hold_vld  = (state_q == RD_HELD);
    assign rdata_sel = hold_vld ? rdata_hold : rdata_in;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage in-order pipeline.
// Registers the EXE->MEM bundle, picks the final write-back value (ALU
// result or load data, with load data held stable across WB stalls) and
// drives the MEM->WB bundle, the ID forwarding port and the MEM handshake.
// Ports:
//   clk    : pipeline clock
//   resetn : asynchronous active-low reset
//   bus    : mem_stage_if.slave
//            in : MEM_signal_valid, EXE_readygo, MEM_signal[70:0],
//                 data_sram_rdata[31:0], WB_allowin
//            out: MEM_allowin, WB_signal_valid, WB_signal[69:0],
//                 MEM_fwd_we, MEM_fwd_waddr[4:0], MEM_fwd_wdata[31:0]
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);

    logic                 vld_p1;
    logic [EXE2MEM_W-1:0] bundle_p1;

    logic        mem_readygo;
    logic        mem_allowin;
    logic        accept;

    logic [31:0] pc_p1;
    logic        res_from_mem_p1;
    logic        rf_we_p1;
    logic [4:0]  rf_waddr_p1;
    logic [31:0] alu_result_p1;

    logic [31:0] load_data;
    logic        hold_vld;
    logic [31:0] final_result;

    // MEM never needs more than one cycle.
    assign mem_readygo = 1'b1;
    assign mem_allowin = !vld_p1 || (mem_readygo && bus.WB_allowin);
    assign accept      = mem_allowin && bus.EXE_readygo;

    // ---- EXE -> MEM pipeline register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1    <= 1'b0;
            bundle_p1 <= '0;
        end else if (mem_allowin) begin
            // An unfinished EXE instruction becomes a bubble so WB never
            // sees the same instruction twice.
            vld_p1 <= bus.EXE_readygo ? bus.MEM_signal_valid : 1'b0;
            if (accept) begin
                bundle_p1 <= bus.MEM_signal;
            end
        end
    end

    assign pc_p1           = bundle_p1[EM_PC_LSB +: 32];
    assign res_from_mem_p1 = bundle_p1[EM_RES_FROM_MEM];
    assign rf_we_p1        = bundle_p1[EM_RF_WE];
    assign rf_waddr_p1     = bundle_p1[EM_WADDR_LSB +: 5];
    assign alu_result_p1   = bundle_p1[EM_ALU_LSB +: 32];

    // Whenever MEM may update it either takes a new bundle or bubbles, so
    // the held load data is stale from that edge on.
    mem_rdata_hold u_rdata_hold (
        .clk       (clk),
        .resetn    (resetn),
        .capture   (vld_p1 && res_from_mem_p1 && !bus.WB_allowin),
        .clear     (mem_allowin),
        .rdata_in  (bus.data_sram_rdata),
        .rdata_sel (load_data),
        .hold_vld  (hold_vld)
    );

    assign final_result = res_from_mem_p1 ? load_data : alu_result_p1;

    // ---- MEM -> WB / forwarding outputs ----
    assign bus.MEM_allowin     = mem_allowin;
    assign bus.WB_signal_valid = vld_p1 && mem_readygo;

    always_comb begin
        bus.WB_signal                        = '0;
        bus.WB_signal[WB_PC_LSB +: 32]       = pc_p1;
        bus.WB_signal[WB_RF_WE]              = rf_we_p1;
        bus.WB_signal[WB_WADDR_LSB +: 5]     = rf_waddr_p1;
        bus.WB_signal[WB_RESULT_LSB +: 32]   = final_result;
    end

    assign bus.MEM_fwd_we    = vld_p1 && rf_we_p1 && (rf_waddr_p1 != 5'd0);
    assign bus.MEM_fwd_waddr = rf_waddr_p1;
    assign bus.MEM_fwd_wdata = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of per-cycle input/expected-output
// rows followed by hand-written sequences for back-to-back loads with a
// stall and for reset asserted during a stall.
module tb_mem_stage;

    logic clk;
    logic resetn;

    mem_stage_if bus ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        v;
        logic        rg;
        logic [70:0] sig;
        logic [31:0] rd;
        logic        wa;
        logic        exp_allowin;
        logic        exp_wbv;
        logic        chk_sig;
        logic [69:0] exp_sig;
        logic        exp_fwd_we;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [70:0] mk_em(input logic [31:0] pc, input logic rfm,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] alu);
        return {pc, rfm, we, wa, alu};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                          input logic [4:0] wa, input logic [31:0] res);
        return {pc, we, wa, res};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic rg, input logic [70:0] sig,
                         input logic [31:0] rd, input logic wa);
        bus.MEM_signal_valid = v;
        bus.EXE_readygo      = rg;
        bus.MEM_signal       = sig;
        bus.data_sram_rdata  = rd;
        bus.WB_allowin       = wa;
    endtask

    task automatic set_row(input int i, input logic v, input logic rg, input logic [70:0] sig,
                           input logic [31:0] rd, input logic wa, input logic e_allow,
                           input logic e_wbv, input logic chk, input logic [69:0] e_sig,
                           input logic e_fwd);
        tbl[i].v = v;  tbl[i].rg = rg;  tbl[i].sig = sig;  tbl[i].rd = rd;  tbl[i].wa = wa;
        tbl[i].exp_allowin = e_allow;  tbl[i].exp_wbv = e_wbv;  tbl[i].chk_sig = chk;
        tbl[i].exp_sig = e_sig;  tbl[i].exp_fwd_we = e_fwd;
    endtask

    initial begin
        logic [70:0] ins_a, ins_l1, ins_junk, ins_l2, ins_n, ins_l3;

        ins_a    = mk_em(32'h1c000010, 1'b0, 1'b1, 5'd5,  32'h00001234);
        ins_l1   = mk_em(32'h1c000020, 1'b1, 1'b1, 5'd7,  32'h00000100);
        ins_junk = mk_em(32'h1c0000ee, 1'b0, 1'b1, 5'd4,  32'h00000099);
        ins_l2   = mk_em(32'h1c000030, 1'b1, 1'b1, 5'd9,  32'h00000200);
        ins_n    = mk_em(32'h1c000040, 1'b0, 1'b1, 5'd10, 32'h00000abc);
        ins_l3   = mk_em(32'h1c000050, 1'b1, 1'b1, 5'd0,  32'h00000000);

        //        i  v  rg sig       rd            wa  allow wbv chk exp_sig                                                fwd
        set_row(0,  1, 1, ins_a,    32'h0,        1,  1,    0,  1,  70'd0,                                                 0);
        set_row(1,  0, 1, 71'd0,    32'h55,       1,  1,    1,  1,  mk_wb(32'h1c000010, 1, 5'd5,  32'h00001234),           1);
        set_row(2,  1, 1, ins_l1,   32'h0,        1,  1,    0,  1,  70'd0,                                                 0);
        set_row(3,  1, 0, ins_junk, 32'hdeadbeef, 1,  1,    1,  1,  mk_wb(32'h1c000020, 1, 5'd7,  32'hdeadbeef),           1);
        set_row(4,  1, 1, ins_l2,   32'h0,        1,  1,    0,  0,  70'd0,                                                 0);
        set_row(5,  1, 1, ins_n,    32'hdeadbeef, 0,  0,    1,  1,  mk_wb(32'h1c000030, 1, 5'd9,  32'hdeadbeef),           1);
        set_row(6,  1, 1, ins_n,    32'h0,        0,  0,    1,  1,  mk_wb(32'h1c000030, 1, 5'd9,  32'hdeadbeef),           1);
        set_row(7,  1, 1, ins_n,    32'hffffffff, 0,  0,    1,  1,  mk_wb(32'h1c000030, 1, 5'd9,  32'hdeadbeef),           1);
        set_row(8,  1, 1, ins_n,    32'h12345678, 1,  1,    1,  1,  mk_wb(32'h1c000030, 1, 5'd9,  32'hdeadbeef),           1);
        set_row(9,  1, 1, ins_l3,   32'h77,       1,  1,    1,  1,  mk_wb(32'h1c000040, 1, 5'd10, 32'h00000abc),           1);
        set_row(10, 0, 1, 71'd0,    32'hcafef00d, 1,  1,    1,  1,  mk_wb(32'h1c000050, 1, 5'd0,  32'hcafef00d),           0);
        set_row(11, 0, 1, 71'd0,    32'h0,        1,  1,    0,  1,  70'd0,                                                 0);

        // Reset state
        resetn = 1'b0;
        drive(1'b0, 1'b0, 71'd0, 32'h0, 1'b0);
        @(negedge clk);
        check("rst_wb_valid", 70'(bus.WB_signal_valid), 70'd0);
        check("rst_allowin",  70'(bus.MEM_allowin),     70'd1);
        check("rst_fwd_we",   70'(bus.MEM_fwd_we),      70'd0);
        check("rst_wb_signal", bus.WB_signal,           70'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven cycle-by-cycle sequence
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rg, tbl[i].sig, tbl[i].rd, tbl[i].wa);
            #1;
            check($sformatf("row%0d_allowin", i),  70'(bus.MEM_allowin),     70'(tbl[i].exp_allowin));
            check($sformatf("row%0d_wb_valid", i), 70'(bus.WB_signal_valid), 70'(tbl[i].exp_wbv));
            check($sformatf("row%0d_fwd_we", i),   70'(bus.MEM_fwd_we),      70'(tbl[i].exp_fwd_we));
            if (tbl[i].chk_sig) begin
                check($sformatf("row%0d_wb_signal", i), bus.WB_signal, tbl[i].exp_sig);
                check($sformatf("row%0d_fwd_wdata", i), 70'(bus.MEM_fwd_wdata), 70'(tbl[i].exp_sig[31:0]));
                check($sformatf("row%0d_fwd_waddr", i), 70'(bus.MEM_fwd_waddr), 70'(tbl[i].exp_sig[36:32]));
            end
        end

        // Back-to-back loads, first one stalls: second must use live rdata
        @(negedge clk);
        drive(1'b1, 1'b1, mk_em(32'h1c000100, 1'b1, 1'b1, 5'd3, 32'h0), 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, mk_em(32'h1c000104, 1'b1, 1'b1, 5'd4, 32'h0), 32'haaaa0001, 1'b0);
        #1;
        check("b2b_first_fresh", bus.WB_signal, mk_wb(32'h1c000100, 1'b1, 5'd3, 32'haaaa0001));
        check("b2b_stall_allowin", 70'(bus.MEM_allowin), 70'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, mk_em(32'h1c000104, 1'b1, 1'b1, 5'd4, 32'h0), 32'hbbbb0002, 1'b1);
        #1;
        check("b2b_first_held", bus.WB_signal, mk_wb(32'h1c000100, 1'b1, 5'd3, 32'haaaa0001));
        @(negedge clk);
        drive(1'b0, 1'b1, 71'd0, 32'hcccc0003, 1'b1);
        #1;
        check("b2b_second_fresh", bus.WB_signal, mk_wb(32'h1c000104, 1'b1, 5'd4, 32'hcccc0003));
        check("b2b_second_valid", 70'(bus.WB_signal_valid), 70'd1);

        // Reset asserted while HELD
        @(negedge clk);
        drive(1'b1, 1'b1, mk_em(32'h1c000200, 1'b1, 1'b1, 5'd6, 32'h0), 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 71'd0, 32'h11110000, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 71'd0, 32'h22220000, 1'b0);
        #1;
        check("rst_stall_held", bus.WB_signal, mk_wb(32'h1c000200, 1'b1, 5'd6, 32'h11110000));
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_wb_valid", 70'(bus.WB_signal_valid), 70'd0);
        check("rst_async_allowin",  70'(bus.MEM_allowin),     70'd1);
        check("rst_async_wb_signal", bus.WB_signal,           70'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 1'b1, mk_em(32'h1c000300, 1'b1, 1'b1, 5'd8, 32'h0), 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 71'd0, 32'h33330000, 1'b1);
        #1;
        check("post_rst_fresh", bus.WB_signal, mk_wb(32'h1c000300, 1'b1, 5'd8, 32'h33330000));
        check("post_rst_valid", 70'(bus.WB_signal_valid), 70'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline. It sits between `exe_stage` and the write-back stage. It registers the 71-bit EXE→MEM bundle and receives the synchronous data-SRAM read data one cycle after EXE issued the request. It keeps that read data stable across write-back stalls, selects the final write-back value, and drives the MEM→WB bundle, a forwarding port for ID, and the MEM-side valid/allowin handshake.

## Interface
- Parameters: none. All widths are fixed by the pipeline bundle formats.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `MEM_signal_valid`  in  1  EXE holds a valid instruction.
- `EXE_readygo`  in  1  EXE has completed its instruction; the ALU result is final.
- `MEM_signal`  in  71  `{pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}`, MSB first.
- `data_sram_rdata`  in  32  read data for the request EXE issued in the previous cycle.
- `WB_allowin`  in  1  WB can accept this cycle.
- `MEM_allowin`  out  1  MEM can accept from EXE this cycle.
- `WB_signal_valid`  out  1  MEM holds a valid, ready instruction.
- `WB_signal`  out  70  `{pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}`.
- `MEM_fwd_we`  out  1  `MEM_valid && rf_we && rf_waddr != 0`.
- `MEM_fwd_waddr`  out  5  destination register for forwarding.
- `MEM_fwd_wdata`  out  32  `final_result`, for ID bypass.

## Operation
- Internal state:
  - `MEM_valid`
  - bundle register `{pc, res_from_mem, rf_we, rf_waddr, alu_result}`
  - `rdata_hold[31:0]`
  - `hold_vld`
- `MEM_readygo = 1` in every cycle.
- `MEM_allowin = !MEM_valid || (MEM_readygo && WB_allowin)`.
- Accept: when `MEM_allowin && EXE_readygo`, load the bundle register and set `MEM_valid <= MEM_signal_valid`.
- When `MEM_allowin && !EXE_readygo`, set `MEM_valid <= 0` (bubble). The bundle register may keep stale contents.
- Read-data capture, two-state FSM per occupancy:
  - FRESH (`hold_vld=0`): the value used is `data_sram_rdata`.
  - HELD (`hold_vld=1`): the value used is `rdata_hold`.
  - FRESH→HELD: `MEM_valid && res_from_mem && !WB_allowin`. On this transition, `rdata_hold <= data_sram_rdata`.
  - HELD→FRESH: any cycle where MEM accepts a new bundle or `MEM_valid` drops.
- Reason for the hold: while MEM stalls, EXE keeps re-issuing its own request, so `data_sram_rdata` no longer belongs to the instruction in MEM.
- `final_result = res_from_mem ? (hold_vld ? rdata_hold : data_sram_rdata) : alu_result`. Loads are word-only.
- `WB_signal_valid = MEM_valid && MEM_readygo`.
- `WB_signal` carries `rf_we` unmodified. WB gates its write with its own valid.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `MEM_valid=0`, `hold_vld=0`, bundle register and `rdata_hold` all zero.
  - Therefore `WB_signal_valid=0`, `MEM_allowin=1`, `MEM_fwd_we=0`, `WB_signal=0`.
  - Reset asserted mid-stall discards the held data.
- Latency: an instruction accepted at edge N is presented to WB during cycle N..N+1 and leaves at the first edge where `WB_allowin=1`.
- Throughput: one instruction per cycle when WB never stalls.
- Simultaneous leave and accept (`MEM_valid && WB_allowin && EXE_readygo`): the new bundle replaces the old one at the same edge, and `hold_vld` clears.
- Stall of k cycles: `WB_signal` is identical in every stalled cycle, even though `data_sram_rdata` changes.
- Load with `WB_allowin=1` in its first cycle: `hold_vld` never sets. The result comes straight from `data_sram_rdata`.
- The forwarding outputs are combinational from state plus `data_sram_rdata`. A load in MEM forwards valid data, so ID only needs to stall on `ld_EXE`.

## Structure
- Shared pipeline package holds:
  - bundle widths `EXE2MEM_W=71` and `MEM2WB_W=70`
  - field offset constants for both bundles
- One natural sub-module: `mem_rdata_hold`, the FRESH/HELD capture register with a `sel`'d output.
- Everything else is inline in `mem_stage`.

## Test plan
- Non-load pass-through: accept `pc=0x1c000010`, `rf_we=1`, `waddr=5`, `alu_result=0x1234` with `WB_allowin=1` → next cycle `WB_signal={0x1c000010,1,5,0x1234}`, `WB_signal_valid=1`, `MEM_fwd_we=1`.
- Load, no stall: accept a load, then `data_sram_rdata=0xDEADBEEF` → `final_result=0xDEADBEEF` in that cycle, and `hold_vld` stays 0.
- Load with a 3-cycle WB stall:
  - Stimulus: rdata `0xDEADBEEF` in the first cycle, then `0x0` and `0xFFFFFFFF`.
  - Required: `final_result` stays `0xDEADBEEF` for all 3 cycles, `MEM_allowin=0` throughout, and the instruction leaves once `WB_allowin=1`.
- EXE not ready: `MEM_signal_valid=1`, `EXE_readygo=0`, `MEM_allowin=1` → `MEM_valid` drops to 0 and no duplicate is sent to WB.
- Back-to-back loads with a stall on the first: the second load uses fresh `data_sram_rdata`, not `rdata_hold`.
- Reset mid-stall: `resetn=0` while HELD → `WB_signal_valid=0` and `MEM_allowin=1` immediately, asynchronously.
